// File: rtl/btb_gshare_predictor_pkg.sv
// Shared constants for the BTB/gshare fetch predictor: indexing modes, FSM encodings
// and the weak counter values used for clearing and allocation.
package btb_gshare_predictor_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;
    localparam int MODE_STATIC  = 2;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int unsigned ctr_weak_taken(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic int unsigned ctr_weak_not_taken(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/btb_gshare_predictor_sat_counter.sv
// Saturating counter next-value logic with load; load wins over inc/dec.
// Latency: combinational, the caller owns the register.
// Backpressure: none.
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (load) begin
            nxt = load_val;
        end else if (inc && !dec && (cur != '1)) begin
            nxt = cur + 1'b1;
        end else if (dec && !inc && (cur != '0)) begin
            nxt = cur - 1'b1;
        end
    end

endmodule

// File: rtl/btb_gshare_predictor.sv
// Fetch-stage predictor: tagged BTB + saturating PHT, bimodal/gshare/static indexing.
// Latency: lookup combinational, all table/history writes land at the next rising edge.
// Backpressure: none; table clear takes 2**IDX_W cycles flagged by init_busy.
module btb_gshare_predictor
    import btb_gshare_predictor_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int IDX_W  = 8,
    parameter int CTR_W  = 2,
    parameter int GHR_W  = 8,
    parameter int MODE   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_valid,
    input  logic [WORD_W-1:0] fetch_pc,
    output logic [WORD_W-1:0] pred_next_pc,
    output logic              pred_taken,
    output logic [GHR_W-1:0]  pred_ghr,
    output logic              init_busy,
    input  logic              upd_valid,
    input  logic [WORD_W-1:0] upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [WORD_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic [GHR_W-1:0]  upd_ghr,
    output logic [15:0]       stat_lookups,
    output logic [15:0]       stat_mispred
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = WORD_W - IDX_W;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_not_taken(CTR_W));
    localparam logic USE_HIST = (MODE == MODE_GSHARE);

    logic [TAG_W-1:0]  tag_mem   [ENTRIES];
    logic [WORD_W-1:0] tgt_mem   [ENTRIES];
    logic              valid_mem [ENTRIES];
    logic              jump_mem  [ENTRIES];
    logic [CTR_W-1:0]  ctr_mem   [ENTRIES];

    logic [0:0]       state;
    logic [IDX_W-1:0] clr_idx;
    logic [GHR_W-1:0] ghr;
    logic [15:0]      lookups_q, lookups_nxt;
    logic [15:0]      mispred_q, mispred_nxt;

    function automatic logic [IDX_W-1:0] table_idx(input logic [WORD_W-1:0] pc,
                                                   input logic [GHR_W-1:0]  hist);
        logic [IDX_W-1:0] h;
        h = USE_HIST ? IDX_W'(hist) : '0;
        return pc[IDX_W-1:0] ^ h;
    endfunction

    // Widening first keeps this legal for a 1-bit history.
    function automatic logic [GHR_W-1:0] shift_hist(input logic [GHR_W-1:0] hist,
                                                    input logic b);
        logic [GHR_W:0] t;
        t = {hist, b};
        return t[GHR_W-1:0];
    endfunction

    logic             run;
    logic [IDX_W-1:0] f_idx, u_idx;
    logic             f_hit, f_jump, u_hit;
    logic             btb_wr, alloc;
    logic [CTR_W-1:0] ctr_nxt;

    assign run = (state == ST_RUN);

    assign f_idx  = table_idx(fetch_pc, ghr);
    assign f_hit  = valid_mem[f_idx] && (tag_mem[f_idx] == fetch_pc[WORD_W-1:IDX_W]);
    assign f_jump = jump_mem[f_idx];

    assign pred_taken   = run && f_hit &&
                          (f_jump || ((MODE != MODE_STATIC) && ctr_mem[f_idx][CTR_W-1]));
    assign pred_next_pc = pred_taken ? tgt_mem[f_idx] : fetch_pc + 1'b1;
    assign pred_ghr     = ghr;
    assign init_busy    = (state == ST_INIT);

    assign u_idx  = table_idx(upd_pc, upd_ghr);
    assign u_hit  = valid_mem[u_idx] && (tag_mem[u_idx] == upd_pc[WORD_W-1:IDX_W]);
    assign btb_wr = upd_taken || upd_is_jump;
    assign alloc  = !u_hit && btb_wr;

    sat_counter #(.W(CTR_W)) u_pht_ctr (
        .cur      (ctr_mem[u_idx]),
        .inc      (!upd_is_jump && upd_taken),
        .dec      (!upd_is_jump && !upd_taken),
        .load     (alloc),
        .load_val (CTR_WT),
        .nxt      (ctr_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state == ST_INIT) begin
                valid_mem[clr_idx] <= 1'b0;
                ctr_mem[clr_idx]   <= CTR_WNT;
            end else if (upd_valid) begin
                ctr_mem[u_idx] <= ctr_nxt;
                if (btb_wr) begin
                    tag_mem[u_idx]   <= upd_pc[WORD_W-1:IDX_W];
                    tgt_mem[u_idx]   <= upd_target;
                    jump_mem[u_idx]  <= upd_is_jump;
                    valid_mem[u_idx] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_INIT;
            clr_idx <= '0;
        end else if (state == ST_INIT) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == {IDX_W{1'b1}}) begin
                state <= ST_RUN;
            end
        end
    end

    // Resolve-stage repair overrides the speculative shift from a same-cycle fetch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ghr <= '0;
        end else if (USE_HIST && run) begin
            if (upd_valid && upd_mispredict) begin
                ghr <= upd_is_jump ? upd_ghr : shift_hist(upd_ghr, upd_taken);
            end else if (fetch_valid && f_hit && !f_jump) begin
                ghr <= shift_hist(ghr, pred_taken);
            end
        end
    end

    sat_counter #(.W(16)) u_stat_lookups (
        .cur      (lookups_q),
        .inc      (run && fetch_valid),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val (16'h0000),
        .nxt      (lookups_nxt)
    );

    sat_counter #(.W(16)) u_stat_mispred (
        .cur      (mispred_q),
        .inc      (run && upd_valid && upd_mispredict),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val (16'h0000),
        .nxt      (mispred_nxt)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            lookups_q <= lookups_nxt;
            mispred_q <= mispred_nxt;
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_mispred = mispred_q;

endmodule

// File: tb/tb_btb_gshare_predictor.sv
// Directed bench: three predictor instances (bimodal, gshare, static) share one stimulus.
module tb_btb_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_valid;
    logic [15:0] fetch_pc;
    logic        upd_valid, upd_is_jump, upd_taken, upd_mispredict;
    logic [15:0] upd_pc, upd_target;
    logic [7:0]  upd_ghr;

    logic [15:0] nx [3];
    logic        tk [3];
    logic [7:0]  gh [3];
    logic        bz [3];
    logic [15:0] lk [3];
    logic [15:0] mp [3];

    int n_total = 0;
    int n_bad   = 0;
    int n_lk    = 0;
    int n_mp    = 0;

    always #5 clk = ~clk;

    btb_gshare_predictor #(.MODE(0)) u_m0 (
        .clk(clk), .reset_n(reset_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_next_pc(nx[0]), .pred_taken(tk[0]), .pred_ghr(gh[0]), .init_busy(bz[0]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .upd_ghr(upd_ghr), .stat_lookups(lk[0]), .stat_mispred(mp[0]));

    btb_gshare_predictor #(.MODE(1)) u_m1 (
        .clk(clk), .reset_n(reset_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_next_pc(nx[1]), .pred_taken(tk[1]), .pred_ghr(gh[1]), .init_busy(bz[1]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .upd_ghr(upd_ghr), .stat_lookups(lk[1]), .stat_mispred(mp[1]));

    btb_gshare_predictor #(.MODE(2)) u_m2 (
        .clk(clk), .reset_n(reset_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_next_pc(nx[2]), .pred_taken(tk[2]), .pred_ghr(gh[2]), .init_busy(bz[2]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .upd_ghr(upd_ghr), .stat_lookups(lk[2]), .stat_mispred(mp[2]));

    typedef struct {
        logic        uv;
        logic [15:0] upc;
        logic        uj;
        logic        ut;
        logic [15:0] utgt;
        logic [15:0] fpc;
        logic [15:0] e [3];
    } vec_t;

    vec_t tv [$];

    function automatic vec_t mk(input logic uv, input logic [15:0] upc, input logic uj,
                                input logic ut, input logic [15:0] utgt, input logic [15:0] fpc,
                                input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        vec_t v;
        v.uv = uv; v.upc = upc; v.uj = uj; v.ut = ut; v.utgt = utgt; v.fpc = fpc;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_upd();
        upd_valid = 1'b0; upd_mispredict = 1'b0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_pc = 16'h0; upd_target = 16'h0; upd_ghr = 8'h0;
    endtask

    task automatic do_upd(input logic [15:0] pc, input logic j, input logic t,
                          input logic [15:0] tgt, input logic m, input logic [7:0] g);
        upd_valid = 1'b1; upd_pc = pc; upd_is_jump = j; upd_taken = t;
        upd_target = tgt; upd_mispredict = m; upd_ghr = g;
        step();
        if (m) n_mp++;
        clear_upd();
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] pc1;
        logic        ok;
        logic        pt, late_mp_seen;
        logic [7:0]  pg;
        int          n;
        const logic [15:0] P = 16'h0A47;

        reset_n = 1'b0; fetch_valid = 1'b0; fetch_pc = 16'h0;
        clear_upd();
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            chk("reset_busy", 32'(bz[k]), 32'd1);
            chk("reset_stats", {lk[k], mp[k]}, 32'd0);
            chk("reset_ghr", 32'(gh[k]), 32'd0);
        end

        // First INIT pass, interrupted by reset at cycle ~100.
        reset_n = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 97; c++) begin
            fetch_valid = 1'b1;
            fetch_pc = 16'(c * 291);
            #1;
            pc1 = fetch_pc + 16'd1;
            for (int k = 0; k < 3; k++)
                if (nx[k] !== pc1 || tk[k] !== 1'b0 || bz[k] !== 1'b1) ok = 1'b0;
            step();
        end
        chk("init1_pred_pc_plus_1", 32'(ok), 32'd1);

        reset_n = 1'b0;
        step(); step();
        chk("midinit_reset_busy", 32'(bz[0]), 32'd1);
        reset_n = 1'b1;

        n = 0;
        ok = 1'b1;
        while (bz[0] && n < 400) begin
            fetch_valid = 1'b1;
            fetch_pc = (n == 10) ? 16'hFFFF : 16'($urandom());
            if (n == 200) begin
                upd_valid = 1'b1; upd_pc = 16'h0077; upd_taken = 1'b1; upd_is_jump = 1'b0;
                upd_target = 16'h0123; upd_mispredict = 1'b1; upd_ghr = 8'hFF;
            end else begin
                clear_upd();
            end
            #1;
            pc1 = fetch_pc + 16'd1;
            for (int k = 0; k < 3; k++)
                if (nx[k] !== pc1 || tk[k] !== 1'b0) ok = 1'b0;
            step();
            n++;
        end
        fetch_valid = 1'b0;
        clear_upd();
        chk("init2_pred_pc_plus_1", 32'(ok), 32'd1);
        chk("init2_busy_cycles", 32'(n), 32'd256);
        for (int k = 0; k < 3; k++) begin
            chk("run_busy_low", 32'(bz[k]), 32'd0);
            chk("init_no_stats", {lk[k], mp[k]}, 32'd0);
        end
        chk("init_ghr_frozen", 32'(gh[1]), 32'd0);

        // Table: bimodal counter training/clamp, jump/alias, allocation rules, static mode.
        tv.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0011, 16'h0011, 16'h0011));
        tv.push_back(mk(1'b1, 16'h0010, 1'b0, 1'b1, 16'h0040, 16'h0010, 16'h0040, 16'h0040, 16'h0011));
        tv.push_back(mk(1'b1, 16'h0010, 1'b0, 1'b1, 16'h0040, 16'h0010, 16'h0040, 16'h0040, 16'h0011));
        tv.push_back(mk(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0040, 16'h0010, 16'h0040, 16'h0040, 16'h0011));
        tv.push_back(mk(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0040, 16'h0010, 16'h0011, 16'h0011, 16'h0011));
        tv.push_back(mk(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0040, 16'h0010, 16'h0011, 16'h0011, 16'h0011));
        tv.push_back(mk(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0040, 16'h0010, 16'h0011, 16'h0011, 16'h0011));
        tv.push_back(mk(1'b1, 16'h0010, 1'b0, 1'b1, 16'h0040, 16'h0010, 16'h0011, 16'h0011, 16'h0011));
        tv.push_back(mk(1'b1, 16'h0010, 1'b0, 1'b1, 16'h0040, 16'h0010, 16'h0040, 16'h0040, 16'h0011));
        tv.push_back(mk(1'b1, 16'h0120, 1'b1, 1'b1, 16'h0300, 16'h0120, 16'h0300, 16'h0300, 16'h0300));
        tv.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0220, 16'h0221, 16'h0221, 16'h0221));
        tv.push_back(mk(1'b1, 16'h0120, 1'b1, 1'b0, 16'h0300, 16'h0120, 16'h0300, 16'h0300, 16'h0300));
        tv.push_back(mk(1'b1, 16'h0033, 1'b0, 1'b0, 16'h0999, 16'h0033, 16'h0034, 16'h0034, 16'h0034));
        tv.push_back(mk(1'b1, 16'h0033, 1'b0, 1'b1, 16'h0500, 16'h0033, 16'h0500, 16'h0500, 16'h0034));
        tv.push_back(mk(1'b1, 16'h0033, 1'b0, 1'b1, 16'h0500, 16'h0033, 16'h0500, 16'h0500, 16'h0034));
        tv.push_back(mk(1'b1, 16'h0033, 1'b0, 1'b0, 16'h0777, 16'h0033, 16'h0500, 16'h0500, 16'h0034));
        tv.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0077, 16'h0078, 16'h0078, 16'h0078));

        foreach (tv[i]) begin
            if (tv[i].uv) do_upd(tv[i].upc, tv[i].uj, tv[i].ut, tv[i].utgt, 1'b0, 8'h00);
            fetch_pc = tv[i].fpc;
            #1;
            pc1 = tv[i].fpc + 16'd1;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("vec%0d_m%0d_next", i, k), 32'(nx[k]), 32'(tv[i].e[k]));
                chk($sformatf("vec%0d_m%0d_taken", i, k), 32'(tk[k]), 32'(tv[i].e[k] != pc1));
            end
        end

        // Gshare: seed both history contexts, set GHR via repair, then run T,N,T,N.
        do_upd(P, 1'b0, 1'b1, 16'h0B00, 1'b0, 8'hAA);
        do_upd(P, 1'b0, 1'b1, 16'h0B00, 1'b0, 8'h55);
        do_upd(16'h0F00, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h55);
        chk("repair_nt_ghr", 32'(gh[1]), 32'hAA);
        chk("bimodal_ghr_zero", 32'(gh[0]), 32'd0);
        chk("static_ghr_zero", 32'(gh[2]), 32'd0);

        late_mp_seen = 1'b0;
        for (int it = 0; it < 16; it++) begin
            fetch_valid = 1'b1;
            fetch_pc = P;
            #1;
            pt = tk[1];
            pg = gh[1];
            if (it >= 12) chk($sformatf("loop%0d_ghr", it), 32'(pg), (it % 2 == 0) ? 32'hAA : 32'h55);
            step();
            n_lk++;
            fetch_valid = 1'b0;
            do_upd(P, 1'b0, (it % 2 == 0), 16'h0B00, pt != (it % 2 == 0), pg);
            if (it >= 12 && pt != (it % 2 == 0)) late_mp_seen = 1'b1;
        end
        chk("loop_last4_no_mispredict", 32'(late_mp_seen), 32'd0);

        // Repair with a simultaneous speculative fetch hit.
        fetch_valid = 1'b1; fetch_pc = P;
        upd_valid = 1'b1; upd_mispredict = 1'b1; upd_is_jump = 1'b0; upd_taken = 1'b1;
        upd_pc = 16'h0F00; upd_target = 16'h0D00; upd_ghr = 8'h3C;
        #1;
        chk("repair_fetch_hits", 32'(tk[1]), 32'd1);
        step();
        n_lk++; n_mp++;
        fetch_valid = 1'b0;
        clear_upd();
        chk("repair_priority_ghr", 32'(gh[1]), 32'h79);
        chk("repair_bimodal_ghr", 32'(gh[0]), 32'd0);
        do_upd(16'h0F00, 1'b1, 1'b1, 16'h0D00, 1'b1, 8'h5A);
        chk("jump_repair_ghr", 32'(gh[1]), 32'h5A);

        // Same-cycle lookup and update on index 0x05.
        fetch_pc = 16'h0005;
        upd_valid = 1'b1; upd_pc = 16'h0005; upd_is_jump = 1'b0; upd_taken = 1'b1;
        upd_target = 16'h0080; upd_mispredict = 1'b0; upd_ghr = 8'h00;
        #1;
        chk("same_cycle_old", 32'(nx[0]), 32'h0006);
        step();
        clear_upd();
        chk("same_cycle_new", 32'(nx[0]), 32'h0080);
        chk("same_cycle_static", 32'(nx[2]), 32'h0006);

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stat_lookups_m%0d", k), 32'(lk[k]), 32'(n_lk));
            chk($sformatf("stat_mispred_m%0d", k), 32'(mp[k]), 32'(n_mp));
        end

        // Saturation of the mispredict counter.
        upd_valid = 1'b1; upd_mispredict = 1'b1; upd_is_jump = 1'b1; upd_taken = 1'b1;
        upd_pc = 16'h0F00; upd_target = 16'h0D00; upd_ghr = 8'h5A;
        repeat (65534 - n_mp) step();
        chk("stat_mispred_fffe", 32'(mp[0]), 32'hFFFE);
        step();
        chk("stat_mispred_ffff", 32'(mp[0]), 32'hFFFF);
        repeat (5) step();
        chk("stat_mispred_sat", 32'(mp[1]), 32'hFFFF);
        clear_upd();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
